systolic_mm_core: RTL and testbench
===================================

Name: systolic_mm_core

Overview:
Parametrised output-stationary systolic matrix-multiply engine. It computes C[ROWS][COLS] = A[ROWS][K] x B[K][COLS] with a runtime depth K. Input skew and a control FSM are built in, and results drain through a valid/ready row stream. It succeeds the fixed N x N array by adding rectangular shapes, operand handshakes, bubble tolerance and flushing.

Parameters:
ROWS, 4, PE rows (A rows, C rows); >=1
COLS, 4, PE columns (B columns, C columns); >=1
DATA_W, 8, signed operand width
ACC_W, 32, signed accumulator width; >= 2*DATA_W
K_MAX, 256, maximum depth; KW = $clog2(K_MAX+1)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
start_i  in  1  begin job; sampled only in IDLE
k_len_i  in  KW  depth K, captured with start_i
busy_o  out  1  high whenever state != IDLE
a_valid_i  in  1  A column beat valid
a_ready_o  out  1  A beat accepted
a_data_i  in  ROWS*DATA_W  A[r][k] at bits [r*DATA_W +: DATA_W]
b_valid_i  in  1  B row beat valid
b_ready_o  out  1  B beat accepted
b_data_i  in  COLS*DATA_W  B[k][c] at bits [c*DATA_W +: DATA_W]
c_valid_o  out  1  result row valid
c_ready_i  in  1  result row consumed
c_data_o  out  COLS*ACC_W  C[row][c] at bits [c*ACC_W +: ACC_W]
c_row_o  out  max(1,$clog2(ROWS))  index of the presented row
c_last_o  out  1  presented row is ROWS-1
done_o  out  1  one-cycle pulse when the last row is accepted

Behaviour:
- Reset: state IDLE, all accumulators, skew registers, counters and valid flags cleared. All outputs 0. Reset mid-job aborts the job with no done_o.
- FSM states: IDLE, STREAM, FLUSH, DRAIN.
- IDLE -> STREAM on start_i when k_len_i != 0. Capture K, clear accumulators, clear beat counter. a_ready_o is first eligible the next cycle.
- IDLE -> DRAIN on start_i when k_len_i == 0. Accumulators are cleared, so zeros drain.
- STREAM handshake:
  - a_ready_o = (state==STREAM) && b_valid_i.
  - b_ready_o = (state==STREAM) && a_valid_i.
  - A beat fires only when a_valid_i && b_valid_i, i.e. A and B are consumed jointly.
- A fired beat enters the skew stage with valid=1. A non-firing cycle injects a bubble (data 0, valid 0). PEs accumulate only when the incoming valid is 1, so bubbles never corrupt results.
- Skew timing:
  - A lane r is delayed r cycles; B lane c is delayed c cycles.
  - Each PE registers A rightward and B downward, each with its own valid bit.
  - Beat k meets at PE(r,c) r+c cycles after firing, and is accumulated on the following edge.
- STREAM -> FLUSH on the cycle the K-th beat fires.
- FLUSH holds for exactly ROWS+COLS-1 cycles, during which no ready is asserted. Then -> DRAIN.
- Arithmetic: PE acc <= acc + sext(a*b), where a*b is a signed 2*DATA_W product. Sign-extend to ACC_W. Wrap modulo 2^ACC_W; no saturation or flag.
- DRAIN:
  - c_valid_o=1; c_row_o counts from 0.
  - c_data_o and c_row_o are held stable while c_valid_o && !c_ready_i.
  - A row advances on c_valid_o && c_ready_i.
  - When row ROWS-1 is accepted: done_o pulses and the state returns to IDLE in the same edge. c_valid_o drops the next cycle.
- start_i outside IDLE is ignored; k_len_i is ignored except on an accepted start.
- Back-to-back jobs: a start_i in the cycle after done_o is legal.

Decomposition:
- Shared package pkg: mm_state_t enum {IDLE, STREAM, FLUSH, DRAIN}, plus ACC_W default constant alongside the existing NUM_BITS/N.
- One sub-module, systolic_mm_pe (mirrors pe but fully parametrised):
  - Ports: clk_i, rst_i, clr_i, a_i/a_valid_i, b_i/b_valid_i, a_o/a_valid_o, b_o/b_valid_o, acc_o.
- Skew shift registers, FSM, counters and drain mux live in systolic_mm_core.

Test Plan:
- 2x2, K=2, A=[[1,2],[3,4]], B=identity, continuous valids -> rows drain [1,2] then [3,4]; done_o pulses once; busy_o falls after.
- 4x4, K=3, random signed values with a bubble every other cycle on b_valid_i -> results equal the reference matmul; no beats lost.
- DATA_W=8, ACC_W=16, K=4, all a=-128, b=-128 -> sum 65536 wraps; every C entry = 0. Then b=127 instead -> every entry -65024 mod 2^16 = 512.
- c_ready_i low for 5 cycles on row 1 -> c_data_o/c_row_o stable; row 2 follows only after acceptance; c_last_o only on row ROWS-1.
- k_len_i=0 start -> goes straight to DRAIN; ROWS rows of zeros; a_ready_o/b_ready_o never assert.
- rst_i asserted mid-STREAM (after 2 of 5 beats), then a new K=1 job -> no done_o from the aborted job; new results equal A[:,0]*B[0,:] only. start_i pulsed during FLUSH is ignored.

Source files
------------

// File: rtl/systolic_mm_pkg.sv
// Shared types and default constants for the systolic matrix-multiply slice.
package systolic_mm_pkg;

  localparam int NUM_BITS  = 8;
  localparam int N         = 4;
  localparam int ACC_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DRAIN  = 2'd3
  } mm_state_t;

endpackage

// File: rtl/systolic_mm_pe.sv
// Output-stationary processing element: forwards A right and B down, and
// accumulates the signed product whenever both incoming operands are valid.
module systolic_mm_pe
  import systolic_mm_pkg::*;
#(
  parameter int DATA_W = NUM_BITS,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic              a_valid_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              b_valid_i,
  output logic [DATA_W-1:0] a_o,
  output logic              a_valid_o,
  output logic [DATA_W-1:0] b_o,
  output logic              b_valid_o,
  output logic [ACC_W-1:0]  acc_o
);

  logic signed [2*DATA_W-1:0] w_prod;
  logic        [ACC_W-1:0]    w_prod_ext;

  assign w_prod     = $signed(a_i) * $signed(b_i);
  assign w_prod_ext = ACC_W'(w_prod);

  // Operand forwarding and wrap-around accumulation; bubbles leave acc untouched.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      a_o       <= '0;
      a_valid_o <= 1'b0;
      b_o       <= '0;
      b_valid_o <= 1'b0;
      acc_o     <= '0;
    end else begin
      a_o       <= a_i;
      a_valid_o <= a_valid_i;
      b_o       <= b_i;
      b_valid_o <= b_valid_i;
      if (a_valid_i && b_valid_i) begin
        acc_o <= acc_o + w_prod_ext;
      end
    end
  end

endmodule

// File: rtl/systolic_mm_core.sv
// Output-stationary systolic matrix multiply: joint A/B beat handshake,
// input skew, ROWS x COLS PE grid, flush wait and valid/ready row drain.
module systolic_mm_core
  import systolic_mm_pkg::*;
#(
  parameter  int ROWS   = N,
  parameter  int COLS   = N,
  parameter  int DATA_W = NUM_BITS,
  parameter  int ACC_W  = ACC_W_DEF,
  parameter  int K_MAX  = 256,
  localparam int KW     = $clog2(K_MAX + 1),
  localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [KW-1:0]          k_len_i,
  output logic                   busy_o,
  input  logic                   a_valid_i,
  output logic                   a_ready_o,
  input  logic [ROWS*DATA_W-1:0] a_data_i,
  input  logic                   b_valid_i,
  output logic                   b_ready_o,
  input  logic [COLS*DATA_W-1:0] b_data_i,
  output logic                   c_valid_o,
  input  logic                   c_ready_i,
  output logic [COLS*ACC_W-1:0]  c_data_o,
  output logic [RW-1:0]          c_row_o,
  output logic                   c_last_o,
  output logic                   done_o
);

  localparam int FW = $clog2(ROWS + COLS);

  mm_state_t        r_state;
  logic [KW-1:0]    r_k;
  logic [KW-1:0]    r_cnt;
  logic [FW-1:0]    r_flush;
  logic [RW-1:0]    r_row;
  logic             r_busy;
  logic             r_cvalid;
  logic             r_done;

  logic             w_fire;
  logic             w_clr;
  logic [COLS*ACC_W-1:0] w_row_data;

  logic [DATA_W-1:0] w_a_lane   [ROWS];
  logic              w_a_lane_v [ROWS];
  logic [DATA_W-1:0] w_b_lane   [COLS];
  logic              w_b_lane_v [COLS];

  logic [DATA_W-1:0] w_ain  [ROWS][COLS];
  logic              w_ainv [ROWS][COLS];
  logic [DATA_W-1:0] w_bin  [ROWS][COLS];
  logic              w_binv [ROWS][COLS];
  logic [DATA_W-1:0] w_pa   [ROWS][COLS];
  logic              w_pav  [ROWS][COLS];
  logic [DATA_W-1:0] w_pb   [ROWS][COLS];
  logic              w_pbv  [ROWS][COLS];
  logic [ACC_W-1:0]  w_acc  [ROWS][COLS];

  assign w_fire    = (r_state == STREAM) && a_valid_i && b_valid_i;
  assign w_clr     = (r_state == IDLE);
  assign a_ready_o = (r_state == STREAM) && b_valid_i;
  assign b_ready_o = (r_state == STREAM) && a_valid_i;
  assign busy_o    = r_busy;
  assign c_valid_o = r_cvalid;
  assign c_row_o   = r_row;
  assign c_last_o  = r_cvalid && (r_row == RW'(ROWS - 1));
  assign done_o    = r_done;
  assign c_data_o  = r_cvalid ? w_row_data : '0;

  // Lane 0 feeds the array straight from the fired beat; lane r adds r register
  // stages, so a beat meets PE(r,c) exactly r+c cycles after it fires.
  for (genvar r = 0; r < ROWS; r++) begin : g_askew
    if (r == 0) begin : g_direct
      assign w_a_lane[r]   = w_fire ? a_data_i[0 +: DATA_W] : '0;
      assign w_a_lane_v[r] = w_fire;
    end else begin : g_delay
      logic [DATA_W-1:0] r_d [r];
      logic              r_v [r];
      // A skew shift register; non-firing cycles shift in bubbles.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          for (int unsigned i = 0; i < r; i++) begin
            r_d[i] <= '0;
            r_v[i] <= 1'b0;
          end
        end else begin
          r_d[0] <= w_fire ? a_data_i[r*DATA_W +: DATA_W] : '0;
          r_v[0] <= w_fire;
          for (int unsigned i = 1; i < r; i++) begin
            r_d[i] <= r_d[i-1];
            r_v[i] <= r_v[i-1];
          end
        end
      end
      assign w_a_lane[r]   = r_d[r-1];
      assign w_a_lane_v[r] = r_v[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_bskew
    if (c == 0) begin : g_direct
      assign w_b_lane[c]   = w_fire ? b_data_i[0 +: DATA_W] : '0;
      assign w_b_lane_v[c] = w_fire;
    end else begin : g_delay
      logic [DATA_W-1:0] r_d [c];
      logic              r_v [c];
      // B skew shift register; non-firing cycles shift in bubbles.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          for (int unsigned i = 0; i < c; i++) begin
            r_d[i] <= '0;
            r_v[i] <= 1'b0;
          end
        end else begin
          r_d[0] <= w_fire ? b_data_i[c*DATA_W +: DATA_W] : '0;
          r_v[0] <= w_fire;
          for (int unsigned i = 1; i < c; i++) begin
            r_d[i] <= r_d[i-1];
            r_v[i] <= r_v[i-1];
          end
        end
      end
      assign w_b_lane[c]   = r_d[c-1];
      assign w_b_lane_v[c] = r_v[c-1];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      if (c == 0) begin : g_aedge
        assign w_ain[r][c]  = w_a_lane[r];
        assign w_ainv[r][c] = w_a_lane_v[r];
      end else begin : g_ainner
        assign w_ain[r][c]  = w_pa[r][c-1];
        assign w_ainv[r][c] = w_pav[r][c-1];
      end
      if (r == 0) begin : g_bedge
        assign w_bin[r][c]  = w_b_lane[c];
        assign w_binv[r][c] = w_b_lane_v[c];
      end else begin : g_binner
        assign w_bin[r][c]  = w_pb[r-1][c];
        assign w_binv[r][c] = w_pbv[r-1][c];
      end

      systolic_mm_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_pe (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (w_clr),
        .a_i       (w_ain[r][c]),
        .a_valid_i (w_ainv[r][c]),
        .b_i       (w_bin[r][c]),
        .b_valid_i (w_binv[r][c]),
        .a_o       (w_pa[r][c]),
        .a_valid_o (w_pav[r][c]),
        .b_o       (w_pb[r][c]),
        .b_valid_o (w_pbv[r][c]),
        .acc_o     (w_acc[r][c])
      );
    end
  end

  // Drain mux: select the accumulator row addressed by the row counter.
  always_comb begin
    w_row_data = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (r_row == RW'(r)) begin
        for (int unsigned c = 0; c < COLS; c++) begin
          w_row_data[c*ACC_W +: ACC_W] = w_acc[r][c];
        end
      end
    end
  end

  // Job control FSM with registered busy/valid/done outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_k      <= '0;
      r_cnt    <= '0;
      r_flush  <= '0;
      r_row    <= '0;
      r_busy   <= 1'b0;
      r_cvalid <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start_i) begin
            r_k    <= k_len_i;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            if (k_len_i != '0) begin
              r_state <= STREAM;
            end else begin
              r_state  <= DRAIN;
              r_row    <= '0;
              r_cvalid <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (w_fire) begin
            r_cnt <= r_cnt + KW'(1);
            if (r_cnt + KW'(1) == r_k) begin
              r_state <= FLUSH;
              r_flush <= '0;
            end
          end
        end
        FLUSH: begin
          if (r_flush == FW'(ROWS + COLS - 2)) begin
            r_state  <= DRAIN;
            r_row    <= '0;
            r_cvalid <= 1'b1;
          end else begin
            r_flush <= r_flush + FW'(1);
          end
        end
        DRAIN: begin
          if (r_cvalid && c_ready_i) begin
            if (r_row == RW'(ROWS - 1)) begin
              r_state  <= IDLE;
              r_row    <= '0;
              r_cvalid <= 1'b0;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
            end else begin
              r_row <= r_row + RW'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_mm_core.sv
// Scoreboard bench for systolic_mm_core: the driver pushes reference rows
// computed by plain matrix arithmetic, a monitor pops them on each accepted row.
module tb_systolic_mm_core;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int DW   = 8;
  localparam int AW   = 16;
  localparam int KMAX = 16;
  localparam int KW   = $clog2(KMAX + 1);
  localparam int RW   = 2;

  logic                 clk;
  logic                 rst;
  logic                 start;
  logic [KW-1:0]        k_len;
  logic                 busy;
  logic                 a_valid, a_ready, b_valid, b_ready;
  logic [ROWS*DW-1:0]   a_data;
  logic [COLS*DW-1:0]   b_data;
  logic                 c_valid, c_ready, c_last, done;
  logic [COLS*AW-1:0]   c_data;
  logic [RW-1:0]        c_row;

  systolic_mm_core #(
    .ROWS   (ROWS),
    .COLS   (COLS),
    .DATA_W (DW),
    .ACC_W  (AW),
    .K_MAX  (KMAX)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .k_len_i   (k_len),
    .busy_o    (busy),
    .a_valid_i (a_valid),
    .a_ready_o (a_ready),
    .a_data_i  (a_data),
    .b_valid_i (b_valid),
    .b_ready_o (b_ready),
    .b_data_i  (b_data),
    .c_valid_o (c_valid),
    .c_ready_i (c_ready),
    .c_data_o  (c_data),
    .c_row_o   (c_row),
    .c_last_o  (c_last),
    .done_o    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [RW-1:0]      row;
    logic [COLS*AW-1:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;
  int   done_exp = 0;
  int   ready_mode = 0;
  int   stall_cnt = 0;

  logic signed [DW-1:0] ma [ROWS][KMAX];
  logic signed [DW-1:0] mb [KMAX][COLS];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: C = A x B over the first k columns/rows, wrapped to AW bits.
  task automatic push_expected(input int k);
    exp_t   x;
    longint s;
    for (int r = 0; r < ROWS; r++) begin
      x.row  = RW'(r);
      x.data = '0;
      for (int c = 0; c < COLS; c++) begin
        s = 0;
        for (int kk = 0; kk < k; kk++) s += longint'(ma[r][kk]) * longint'(mb[kk][c]);
        x.data[c*AW +: AW] = s[AW-1:0];
      end
      sb.push_back(x);
    end
  endtask

  // Result acceptor: always ready, random, or a 5-cycle stall on row 1.
  always @(posedge clk) begin
    #1;
    if (ready_mode == 2 && c_valid && c_row == 2'd1 && stall_cnt < 5) begin
      c_ready = 1'b0;
      stall_cnt++;
    end else if (ready_mode == 1) begin
      c_ready = 1'($urandom % 2);
    end else begin
      c_ready = 1'b1;
    end
  end

  logic               stalled = 1'b0;
  logic [COLS*AW-1:0] held_data;
  logic [RW-1:0]      held_row;

  // Monitor: stability under back-pressure, row/data/last on acceptance, done pulses.
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled && c_valid) begin
        check("hold_data", 64'(c_data), 64'(held_data));
        check("hold_row", 64'(c_row), 64'(held_row));
      end
      if (c_valid && c_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_row actual=row%0d required=none", c_row);
        end else begin
          e = sb.pop_front();
          check("c_row", 64'(c_row), 64'(e.row));
          check("c_data", 64'(c_data), 64'(e.data));
          check("c_last", 64'(c_last), 64'(e.row == RW'(ROWS - 1)));
        end
      end
      stalled   = c_valid && !c_ready;
      held_data = c_data;
      held_row  = c_row;
      if (done) begin
        done_seen++;
        check("busy_after_done", 64'(busy), 64'(0));
      end
    end
  end

  task automatic start_job(input int k);
    @(posedge clk); #1;
    start = 1'b1;
    k_len = KW'(k);
    @(posedge clk); #1;
    start = 1'b0;
    k_len = KW'($urandom);
  endtask

  // Stream nbeats beats; bmode 0 = always valid, 1 = random, 2 = every other cycle.
  task automatic stream(input int nbeats, input int amode, input int bmode);
    int idx = 0;
    int n = 0;
    while (idx < nbeats && n < 500) begin
      a_valid = (amode == 1) ? 1'($urandom % 2) : 1'b1;
      b_valid = (bmode == 1) ? 1'($urandom % 2) : (bmode == 2) ? 1'(n % 2) : 1'b1;
      for (int r = 0; r < ROWS; r++) a_data[r*DW +: DW] = ma[r][idx];
      for (int c = 0; c < COLS; c++) b_data[c*DW +: DW] = mb[idx][c];
      @(negedge clk);
      check("a_ready", 64'(a_ready), 64'(b_valid));
      check("b_ready", 64'(b_ready), 64'(a_valid));
      if (a_valid && a_ready && b_valid && b_ready) idx++;
      n++;
      @(posedge clk); #1;
    end
    if (idx < nbeats) check("stream_timeout", 64'(idx), 64'(nbeats));
    a_valid = 1'b1;
    b_valid = 1'b1;
    a_data  = ROWS*DW'($urandom);
    b_data  = COLS*DW'($urandom);
  endtask

  // Wait for the job to finish; operand valids are held high so any stray ready shows.
  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      check("a_ready_off", 64'(a_ready), 64'(0));
      check("b_ready_off", 64'(b_ready), 64'(0));
      n++;
    end while (busy && n < 3000);
    if (busy) check("idle_timeout", 64'(busy), 64'(0));
  endtask

  task automatic run_job(input int k, input int amode, input int bmode, input bit poke_flush);
    start_job(k);
    push_expected(k);
    done_exp++;
    if (k > 0) stream(k, amode, bmode);
    else begin
      a_valid = 1'b1;
      b_valid = 1'b1;
    end
    if (poke_flush) begin
      start = 1'b1;
      k_len = KW'(3);
      @(posedge clk); #1;
      start = 1'b0;
    end
    wait_idle();
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic fill_random();
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < KMAX; k++) ma[r][k] = DW'($urandom);
    for (int k = 0; k < KMAX; k++)
      for (int c = 0; c < COLS; c++) mb[k][c] = DW'($urandom);
  endtask

  task automatic fill_const(input logic signed [DW-1:0] av, input logic signed [DW-1:0] bv);
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < KMAX; k++) ma[r][k] = av;
    for (int k = 0; k < KMAX; k++)
      for (int c = 0; c < COLS; c++) mb[k][c] = bv;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; k_len = '0;
    a_valid = 1'b0; b_valid = 1'b1; a_data = '0; b_data = '0; c_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_c_valid", 64'(c_valid), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_a_ready", 64'(a_ready), 64'(0));
    check("rst_c_data", 64'(c_data), 64'(0));
    check("rst_c_row", 64'(c_row), 64'(0));
    check("rst_c_last", 64'(c_last), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    b_valid = 1'b0;

    // 2x2 content in the upper-left corner, B = identity.
    fill_const(0, 0);
    ma[0][0] = 1; ma[0][1] = 2; ma[1][0] = 3; ma[1][1] = 4;
    mb[0][0] = 1; mb[1][1] = 1;
    run_job(2, 0, 0, 1'b0);

    // Random values, B bubble every other cycle, start poked during FLUSH.
    fill_random();
    run_job(3, 0, 2, 1'b1);

    // Accumulator wrap at 16 bits.
    fill_const(-128, -128);
    run_job(4, 0, 0, 1'b0);
    fill_const(-128, 127);
    run_job(4, 0, 0, 1'b0);

    // Back-pressure on row 1.
    fill_random();
    stall_cnt = 0;
    ready_mode = 2;
    run_job(5, 1, 0, 1'b0);
    ready_mode = 0;

    // Zero-depth job drains zeros and never raises ready.
    run_job(0, 0, 0, 1'b0);

    // Abort mid-stream, then a single-beat job.
    fill_random();
    start_job(5);
    stream(2, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'(0));
    fill_random();
    run_job(1, 0, 0, 1'b0);

    // Randomised jobs with bubbles on both sides and random acceptance.
    ready_mode = 1;
    for (int j = 0; j < 6; j++) begin
      fill_random();
      run_job(int'($urandom_range(1, KMAX)), 1, 1, 1'b0);
    end
    ready_mode = 0;

    repeat (4) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'(0));
    check("done_count", 64'(done_seen), 64'(done_exp));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
